// File: rtl/reset_seq_pkg.sv
// Shared state encoding and sizing helpers for the reset sequencer.
// Imported by the sequencer top and its synchronizer.
package reset_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t HOLD    = 3'd0;
    localparam state_t GAP     = 3'd1;
    localparam state_t RELEASE = 3'd2;
    localparam state_t RUN     = 3'd3;
    localparam state_t DRAIN   = 3'd4;
    localparam state_t ACK     = 3'd5;

    function automatic int cnt_w(input int gap_cycles);
        return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
    endfunction

    function automatic int idx_w(input int n_domains);
        return (n_domains <= 1) ? 1 : $clog2(n_domains);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset deassertion synchronizer: async clear, release after
// SYNC_STAGES rising edges.
module reset_sync_chain
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered multi-domain reset release with a software re-reset
// handshake; every output is a flop.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int N_DOMAINS   = 4,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw_rst_req,
    output logic                 sw_rst_ack,
    output logic [N_DOMAINS-1:0] dom_rst_n,
    output logic                 seq_done
);

    localparam int CW = cnt_w(GAP_CYCLES);
    localparam int IW = idx_w(N_DOMAINS);

    localparam logic [CW-1:0] CNT_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DOMAINS - 1);

    logic          rst_sync_n;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    reset_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (rst_sync_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HOLD;
            cnt        <= '0;
            idx        <= '0;
            dom_rst_n  <= '0;
            seq_done   <= 1'b0;
            sw_rst_ack <= 1'b0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (rst_sync_n) begin
                        state <= GAP;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                GAP: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    for (int k = 0; k < N_DOMAINS; k++) begin
                        if (idx == IW'(k)) begin
                            dom_rst_n[k] <= 1'b1;
                        end
                    end
                    if (idx == IDX_LAST) begin
                        state    <= RUN;
                        seq_done <= 1'b1;
                    end else begin
                        state <= GAP;
                        idx   <= idx + IW'(1);
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // Request is only honoured here; elsewhere it is dropped.
                    if (sw_rst_req) begin
                        state     <= DRAIN;
                        dom_rst_n <= '0;
                        seq_done  <= 1'b0;
                        cnt       <= '0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state      <= ACK;
                        sw_rst_ack <= 1'b1;
                    end
                end
                ACK: begin
                    if (!sw_rst_req) begin
                        state      <= GAP;
                        sw_rst_ack <= 1'b0;
                        idx        <= '0;
                        cnt        <= '0;
                    end
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: default build plus a
// minimal 1-domain build, checked against a timing-rule model.
module tb_reset_sequencer;

    localparam int S = 3;
    localparam int N = 4;
    localparam int G = 16;
    localparam int P = G + 1;
    localparam int R = S + 1 + N * P;

    localparam int S1 = 2;
    localparam int N1 = 1;
    localparam int G1 = 1;
    localparam int P1 = G1 + 1;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       ack;
    logic [3:0] dom;
    logic       done;

    logic       rst_n1;
    logic       req1;
    logic       ack1;
    logic [0:0] dom1;
    logic       done1;

    int n_checks;
    int n_fail;

    reset_sequencer #(
        .SYNC_STAGES (S),
        .N_DOMAINS   (N),
        .GAP_CYCLES  (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (req),
        .sw_rst_ack (ack),
        .dom_rst_n  (dom),
        .seq_done   (done)
    );

    reset_sequencer #(
        .SYNC_STAGES (S1),
        .N_DOMAINS   (N1),
        .GAP_CYCLES  (G1)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n1),
        .sw_rst_req (req1),
        .sw_rst_ack (ack1),
        .dom_rst_n  (dom1),
        .seq_done   (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {dom[3:0], done} expected e edges after a reference point,
    // when the release sequence begins off edges after that point.
    function automatic logic [4:0] exp_run(int e, int off, int n, int p);
        logic [4:0] v;
        v = '0;
        for (int k = 0; k < n; k++)
            v[k+1] = (e >= off + (k + 1) * p);
        v[0] = (e >= off + n * p);
        return v;
    endfunction

    task automatic check_seq(input int off, input int ncyc, input string tag);
        logic [4:0] v;
        for (int e = 1; e <= ncyc; e++) begin
            tick();
            v = exp_run(e, off, N, P);
            n_checks++;
            if ({dom, done, ack} !== {v, 1'b0}) begin
                n_fail++;
                $display("FAIL %s e=%0d got dom=%b done=%b ack=%b want dom=%b done=%b ack=0",
                         tag, e, dom, done, ack, v[4:1], v[0]);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        n_checks++;
        if ({dom, done, ack} !== 6'b0) begin
            n_fail++;
            $display("FAIL %s got dom=%b done=%b ack=%b want all zero",
                     tag, dom, done, ack);
        end
    endtask

    task automatic test_reset();
        int hold;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        hold = $urandom_range(2, 6);
        repeat (hold) begin
            tick();
            check_zero("reset_hold");
        end
    endtask

    task automatic test_power_on(input int low);
        rst_n = 1'b0;
        repeat (low) tick();
        rst_n = 1'b1;
        check_seq(S + 1, R + 3, "power_on");
    endtask

    task automatic test_sw_drain(input int idle, input int hold);
        logic want_ack;
        repeat (idle) begin
            tick();
            n_checks++;
            if ({dom, done, ack} !== 6'b111110) begin
                n_fail++;
                $display("FAIL run_idle got dom=%b done=%b ack=%b want dom=1111 done=1 ack=0",
                         dom, done, ack);
            end
        end
        req = 1'b1;
        for (int e = 1; e <= G + 1 + hold; e++) begin
            tick();
            want_ack = (e >= G + 1);
            n_checks++;
            if ({dom, done, ack} !== {5'b0, want_ack}) begin
                n_fail++;
                $display("FAIL drain e=%0d got dom=%b done=%b ack=%b want dom=0000 done=0 ack=%b",
                         e, dom, done, ack, want_ack);
            end
        end
        req = 1'b0;
        check_seq(1, 1 + N * P + 2, "rerelease");
    endtask

    task automatic test_early_req(input int t_req);
        logic [4:0] v;
        logic       want_ack;
        rst_n = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        check_seq(S + 1, t_req, "early_pre");
        req = 1'b1;
        for (int e = t_req + 1; e <= R + G + 3; e++) begin
            tick();
            if (e <= R) begin
                v = exp_run(e, S + 1, N, P);
                want_ack = 1'b0;
            end else begin
                v = '0;
                want_ack = (e >= R + 1 + G);
            end
            n_checks++;
            if ({dom, done, ack} !== {v, want_ack}) begin
                n_fail++;
                $display("FAIL early_req e=%0d got dom=%b done=%b ack=%b want dom=%b done=%b ack=%b",
                         e, dom, done, ack, v[4:1], v[0], want_ack);
            end
        end
        req = 1'b0;
        check_seq(1, 1 + N * P + 2, "early_rerelease");
    endtask

    task automatic test_pulse(input int plen);
        logic want_ack;
        req = 1'b1;
        for (int e = 1; e <= G + 1; e++) begin
            tick();
            want_ack = (e == G + 1);
            n_checks++;
            if ({dom, done, ack} !== {5'b0, want_ack}) begin
                n_fail++;
                $display("FAIL pulse e=%0d got dom=%b done=%b ack=%b want dom=0000 done=0 ack=%b",
                         e, dom, done, ack, want_ack);
            end
            if (e == plen) req = 1'b0;
        end
        check_seq(1, 1 + N * P + 2, "pulse_rerelease");
    endtask

    task automatic test_mid_reset();
        int stop;
        int hold;
        rst_n = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        stop = $urandom_range(S + 1 + 2 * P, S + 3 * P);
        check_seq(S + 1, stop, "mid_pre");
        rst_n = 1'b0;
        #1;
        check_zero("mid_async");
        hold = $urandom_range(1, 4);
        repeat (hold) begin
            tick();
            check_zero("mid_hold");
        end
        rst_n = 1'b1;
        check_seq(S + 1, R + 3, "mid_restart");
    endtask

    task automatic test_ignored();
        int a;
        int b;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        a = $urandom_range(1, R - 10);
        b = $urandom_range(a, R - 1);
        for (int e = 1; e <= R + 20; e++) begin
            logic [4:0] v;
            tick();
            v = exp_run(e, S + 1, N, P);
            n_checks++;
            if ({dom, done, ack} !== {v, 1'b0}) begin
                n_fail++;
                $display("FAIL ignored e=%0d got dom=%b done=%b ack=%b want dom=%b done=%b ack=0",
                         e, dom, done, ack, v[4:1], v[0]);
            end
            if (e == a) req = 1'b1;
            if (e == b) req = 1'b0;
        end
    endtask

    task automatic test_small();
        logic [4:0] v;
        logic       want_ack;
        n_checks++;
        if ({dom1, done1, ack1} !== 3'b0) begin
            n_fail++;
            $display("FAIL small_reset got dom=%b done=%b ack=%b want 0 0 0",
                     dom1, done1, ack1);
        end
        rst_n1 = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            v = exp_run(e, S1 + 1, N1, P1);
            n_checks++;
            if ({dom1, done1, ack1} !== {v[1], v[0], 1'b0}) begin
                n_fail++;
                $display("FAIL small_por e=%0d got dom=%b done=%b ack=%b want dom=%b done=%b ack=0",
                         e, dom1, done1, ack1, v[1], v[0]);
            end
        end
        req1 = 1'b1;
        for (int e = 1; e <= G1 + 3; e++) begin
            tick();
            want_ack = (e >= G1 + 1);
            n_checks++;
            if ({dom1, done1, ack1} !== {2'b0, want_ack}) begin
                n_fail++;
                $display("FAIL small_drain e=%0d got dom=%b done=%b ack=%b want dom=0 done=0 ack=%b",
                         e, dom1, done1, ack1, want_ack);
            end
        end
        req1 = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            v = exp_run(e, 1, N1, P1);
            n_checks++;
            if ({dom1, done1, ack1} !== {v[1], v[0], 1'b0}) begin
                n_fail++;
                $display("FAIL small_rerelease e=%0d got dom=%b done=%b ack=%b want dom=%b done=%b ack=0",
                         e, dom1, done1, ack1, v[1], v[0]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        rst_n1   = 1'b1;
        req      = 1'b0;
        req1     = 1'b0;
        tick();
        rst_n1 = 1'b0;
        tick();

        test_reset();
        test_power_on(5);
        test_sw_drain(4, 3);
        test_early_req(20);
        test_pulse(5);
        test_mid_reset();
        test_ignored();
        test_early_req($urandom_range(1, R - 1));
        for (int i = 0; i < 3; i++) begin
            test_sw_drain($urandom_range(0, 10), $urandom_range(0, 10));
            test_pulse($urandom_range(1, G - 1));
        end
        test_power_on($urandom_range(1, 8));
        test_small();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
